// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter sequencer.
// Default widths/depths used by pc_seq and pc_ras.
package pc_pkg;

    localparam int unsigned DEF_PC_W       = 16;
    localparam int unsigned DEF_RAS_DEPTH  = 4;
    localparam int unsigned DEF_PROG_CNT_W = 2;

    typedef logic [DEF_PC_W-1:0] pc_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_seq: LIFO of return addresses with synchronous clear.
// Entry storage is never reset; only the stack pointer is.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned W     = DEF_PC_W,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam logic [SpW-1:0]  SpOne  = SpW'(1);
    localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

    logic [W-1:0]    mem_q [2**IdxW];
    logic [SpW-1:0]  sp_q = '0;
    logic [SpW-1:0]  sp_d;
    logic [IdxW-1:0] top_idx;

    assign empty = (sp_q == '0);
    assign full  = (sp_q == SpW'(DEPTH));

    // Low index bits wrap correctly even when sp == DEPTH is a power of two.
    assign top_idx = sp_q[IdxW-1:0] - IdxOne;
    assign dout    = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (pop && !empty) begin
            sp_d = sp_q - SpOne;
        end else if (push && !full) begin
            sp_d = sp_q + SpOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[IdxW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential step, relative/absolute jumps, call/return, program index.
// Define PC_SEQ_RAS_EN to build in the return-address stack; otherwise call = jump_abs, ret = PC+1.
module pc_seq
    import pc_pkg::*;
#(
    parameter int unsigned PC_W       = DEF_PC_W,
    parameter int unsigned RAS_DEPTH  = DEF_RAS_DEPTH,
    parameter int unsigned PROG_CNT_W = DEF_PROG_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  jump_rel,
    input  logic                  jump_abs,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  done,
    input  logic [PC_W-1:0]       target,
    output logic [PC_W-1:0]       PC,
    output logic [PROG_CNT_W-1:0] prog_id,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_err
);

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_bad_depth
        $error("pc_seq: RAS_DEPTH must be in 2..16");
    end

    localparam logic [PC_W-1:0]       PcOne   = PC_W'(1);
    localparam logic [PROG_CNT_W-1:0] ProgOne = PROG_CNT_W'(1);

    // Power-up values let the block run without an initial reset pulse.
    logic [PC_W-1:0]       pc_q   = '0;
    logic [PC_W-1:0]       pc_d;
    logic [PROG_CNT_W-1:0] prog_q = '0;
    logic [PROG_CNT_W-1:0] prog_d;
    logic [PC_W-1:0]       pc_inc;

    assign pc_inc  = pc_q + PcOne;
    assign PC      = pc_q;
    assign prog_id = prog_q;

`ifdef PC_SEQ_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clr;
    logic [PC_W-1:0] ras_top;
    logic            err_q = 1'b0;
    logic            err_d;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .clr   (ras_clr),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign ras_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    always_comb begin
        pc_d   = pc_q;
        prog_d = prog_q;
`ifdef PC_SEQ_RAS_EN
        err_d    = err_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_clr  = 1'b0;
`endif
        if (!init) begin
            if (done) begin
                prog_d = prog_q + ProgOne;
            end
`ifdef PC_SEQ_RAS_EN
            ras_clr = done;
            if (ret) begin
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end else if (call) begin
                pc_d = target;
                if (ras_full) begin
                    err_d = 1'b1;
                end else begin
                    ras_push = 1'b1;
                end
            end else
`else
            if (ret) begin
                pc_d = pc_inc;
            end else if (call) begin
                pc_d = target;
            end else
`endif
            if (jump_rel) begin
                pc_d = pc_q + target;
            end else if (jump_abs) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            prog_q <= '0;
        end else begin
            pc_q   <= pc_d;
            prog_q <= prog_d;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: queue-based reference model, per-cycle compare, directed
// literal expectations and a randomized phase. Honours PC_SEQ_RAS_EN like the design.
module tb_pc_seq;
    import pc_pkg::*;

    localparam int DEPTH = 4;
    localparam int MODW  = 65536;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       init     = 1'b0;
    logic       jump_rel = 1'b0;
    logic       jump_abs = 1'b0;
    logic       call     = 1'b0;
    logic       ret      = 1'b0;
    logic       done     = 1'b0;
    pc_t        target   = '0;
    logic [15:0] PC;
    logic [1:0]  prog_id;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int checks    = 0;
    int errors    = 0;
    bit check_en  = 1'b0;

    int m_pc   = 0;
    int m_prog = 0;
    int m_err  = 0;
    int stk[$];

    pc_seq #(
        .PC_W       (16),
        .RAS_DEPTH  (DEPTH),
        .PROG_CNT_W (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .jump_rel  (jump_rel),
        .jump_abs  (jump_abs),
        .call      (call),
        .ret       (ret),
        .done      (done),
        .target    (target),
        .PC        (PC),
        .prog_id   (prog_id),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour: what the next state must be given the inputs at this edge.
    task automatic model_step();
        int nxt;
        if (reset) begin
            m_pc = 0; m_prog = 0; m_err = 0;
            stk.delete();
        end else if (!init) begin
            if (ret) begin
                if (RAS && stk.size() > 0) begin
                    nxt = stk.pop_back();
                end else begin
                    nxt = (m_pc + 1) % MODW;
                    if (RAS) m_err = 1;
                end
            end else if (call) begin
                nxt = int'(target);
                if (RAS) begin
                    if (stk.size() < DEPTH) stk.push_back((m_pc + 1) % MODW);
                    else m_err = 1;
                end
            end else if (jump_rel) begin
                nxt = (m_pc + int'(target)) % MODW;
            end else if (jump_abs) begin
                nxt = int'(target);
            end else begin
                nxt = (m_pc + 1) % MODW;
            end
            if (done) begin
                m_prog = (m_prog + 1) % 4;
                stk.delete();
            end
            m_pc = nxt;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", int'(PC), m_pc);
            chk("prog_id", int'(prog_id), m_prog);
            chk("ras_empty", int'(ras_empty), RAS ? int'(stk.size() == 0) : 1);
            chk("ras_full", int'(ras_full), RAS ? int'(stk.size() == DEPTH) : 0);
            chk("ras_err", int'(ras_err), m_err);
        end
    end

    task automatic cyc(input bit r, input bit i, input bit jr, input bit ja, input bit c,
                       input bit rt, input bit d, input int t);
        reset = r; init = i; jump_rel = jr; jump_abs = ja;
        call = c; ret = rt; done = d; target = pc_t'(t);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rst();             cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic jabs(input int t); cyc(0, 0, 0, 1, 0, 0, 0, t); endtask
    task automatic jrel(input int t); cyc(0, 0, 1, 0, 0, 0, 0, t); endtask
    task automatic dcall(input int t); cyc(0, 0, 0, 0, 1, 0, 0, t); endtask
    task automatic dret();            cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic pdone();           cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask

    initial begin
        #1;
        chk("powerup_pc", int'(PC), 0);

        check_en = 1'b1;
        rst();
        chk("rst_pc", int'(PC), 0);
        chk("rst_prog", int'(prog_id), 0);
        chk("rst_err", int'(ras_err), 0);
        chk("rst_empty", int'(ras_empty), 1);

        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("seq_pc", int'(PC), i);
        end
        chk("seq_prog", int'(prog_id), 0);

        jabs(10);
        chk("jabs_pc", int'(PC), 10);
        jrel(16'hFFFC);
        chk("jrel_neg_pc", int'(PC), 6);
        jabs(16'hFFFF);
        idle();
        chk("wrap_pc", int'(PC), 0);

        jabs(20);
        dcall(100);
        chk("call_pc", int'(PC), 100);
        chk("call_empty", int'(ras_empty), RAS ? 0 : 1);
        idle(); idle(); idle();
        chk("pre_ret_pc", int'(PC), 103);
        dret();
        chk("ret_pc", int'(PC), RAS ? 21 : 104);
        chk("ret_empty", int'(ras_empty), 1);

        rst();
        jabs(20);
        dcall(200); dcall(300); dcall(400); dcall(500);
        chk("nest_full", int'(ras_full), RAS ? 1 : 0);
        chk("nest_err4", int'(ras_err), 0);
        dcall(600);
        chk("nest_pc5", int'(PC), 600);
        chk("nest_err5", int'(ras_err), RAS ? 1 : 0);
        idle();
        dret();
        chk("nest_ret_pc", int'(PC), RAS ? 401 : 602);
        chk("err_sticky", int'(ras_err), RAS ? 1 : 0);
        rst();
        chk("err_cleared", int'(ras_err), 0);

        dret();
        chk("ret_empty_pc", int'(PC), 1);
        chk("ret_empty_err", int'(ras_err), RAS ? 1 : 0);
        rst();

        dcall(70);
        cyc(0, 0, 0, 0, 1, 1, 0, 90);
        chk("ret_beats_call", int'(PC), RAS ? 1 : 71);

        jabs(40);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 0, 0, 1, 50);
            chk("init_pc", int'(PC), 40);
            chk("init_prog", int'(prog_id), 0);
        end
        idle();
        chk("init_resume", int'(PC), 41);
        cyc(1, 1, 0, 1, 0, 0, 0, 50);
        chk("rst_over_init", int'(PC), 0);

        dcall(300);
        for (int i = 1; i <= 4; i++) begin
            pdone();
            chk("done_prog", int'(prog_id), i % 4);
            chk("done_pc", int'(PC), 300 + i);
            chk("done_clears", int'(ras_empty), 1);
        end

        rst();
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(63) == 0, $urandom_range(7) == 0,
                $urandom_range(3) == 0, $urandom_range(3) == 0,
                $urandom_range(3) == 0, $urandom_range(3) == 0,
                $urandom_range(15) == 0, int'($urandom_range(65535)));
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
